// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer tick scheduler.
// Holds the interval-timer register map, control register bit positions,
// canned control words and the scheduler FSM state type.
package timer_sched_pkg;

  // Interval-timer register addresses
  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  // Control register bit positions
  localparam int unsigned ITO   = 0;
  localparam int unsigned CONT  = 1;
  localparam int unsigned START = 2;
  localparam int unsigned STOP  = 3;

  localparam logic [15:0] CTRL_RUN  = 16'h0007;  // START | CONT | ITO
  localparam logic [15:0] CTRL_STOP = 16'h0008;  // STOP

  typedef enum logic [3:0] {
    ST_RESET,
    ST_INIT_STOP,
    ST_WR_PL,
    ST_WR_PH,
    ST_WR_CTRL,
    ST_RD_CTRL,
    ST_CHK,
    ST_IDLE,
    ST_CLR
  } sched_state_e;

endpackage

// File: rtl/timer_sched_channel.sv
// One divided event channel of the timer tick scheduler.
// Counts base ticks and emits a one-cycle event every div_eff ticks,
// where a zero divisor behaves as a divisor of one.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   i_tick       : one-cycle base tick strobe
//   i_en         : channel enable; when low the counter is held at zero
//   i_div        : divisor, sampled on each tick
//   o_event      : one-cycle event pulse
module timer_sched_channel #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_tick,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_event
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_event;
  logic [DIV_W-1:0] w_div_eff;
  logic [DIV_W:0]   w_cnt_inc;
  logic             w_fire;

  assign w_div_eff = (i_div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : i_div;
  // One extra bit so cnt+1 cannot wrap before the compare
  assign w_cnt_inc = {1'b0, r_cnt} + {{DIV_W{1'b0}}, 1'b1};
  assign w_fire    = (w_cnt_inc >= {1'b0, w_div_eff});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_event <= 1'b0;
    end else begin
      r_event <= 1'b0;
      if (!i_en) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (w_fire) begin
          r_event <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_inc[DIV_W-1:0];
        end
      end
    end
  end

  assign o_event = r_event;

endmodule

// File: rtl/timer_tick_scheduler.sv
// Avalon-MM master owning a single 16-bit interval timer.
// Programs the timer period after reset and on request, starts it in
// continuous mode with IRQ enabled, checks the control register by
// read-back, services each timeout by clearing status, counts ticks and
// fans the tick out to NUM_CH divided event channels.
// Ports:
//   clk, reset_n             : clock, asynchronous active-low reset
//   cfg_period / cfg_load    : new period and one-cycle reprogram request
//   cfg_busy                 : programming pending or in progress
//   cfg_error                : control read-back mismatch (sticky until next check)
//   ch_en / ch_div           : per-channel enable and divisor
//   ch_event                 : per-channel one-cycle event
//   tick_count               : serviced timeout count
//   tmr_*                    : Avalon-MM master port to the timer
module timer_tick_scheduler
  import timer_sched_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned DIV_W          = 16,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h002FAF07
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             cfg_period,
  input  logic                    cfg_load,
  output logic                    cfg_busy,
  output logic                    cfg_error,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  output logic [NUM_CH-1:0]       ch_event,
  output logic [31:0]             tick_count,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic [15:0]             tmr_readdata,
  input  logic                    tmr_irq
);

  sched_state_e r_state;
  sched_state_e w_next;
  logic [31:0]  r_period;
  logic         r_pend;
  logic         r_error;
  logic [31:0]  r_tick_count;
  logic         w_pend_take;
  logic         w_tick;
  logic         w_unused_rd;

  assign w_unused_rd = ^tmr_readdata[15:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pend_take = 1'b0;
    case (r_state)
      ST_RESET:     w_next = ST_INIT_STOP;
      ST_INIT_STOP: w_next = ST_WR_PL;
      ST_WR_PL:     w_next = ST_WR_PH;
      ST_WR_PH:     w_next = ST_WR_CTRL;
      ST_WR_CTRL:   w_next = ST_RD_CTRL;
      ST_RD_CTRL:   w_next = ST_CHK;
      ST_CHK:       w_next = ST_IDLE;
      ST_IDLE: begin
        if (tmr_irq) begin
          w_next = ST_CLR;
        end else if (r_pend) begin
          w_next      = ST_INIT_STOP;
          w_pend_take = 1'b1;
        end
      end
      ST_CLR:       w_next = ST_IDLE;
      default:      w_next = ST_RESET;
    endcase
  end

  // Bus outputs decode the registered state only
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = TMR_STATUS;
    tmr_writedata  = '0;
    case (r_state)
      ST_INIT_STOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_CONTROL;
        tmr_writedata  = CTRL_STOP;
      end
      ST_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_PERIODL;
        tmr_writedata  = r_period[15:0];
      end
      ST_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_PERIODH;
        tmr_writedata  = r_period[31:16];
      end
      ST_WR_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_CONTROL;
        tmr_writedata  = CTRL_RUN;
      end
      ST_RD_CTRL: begin
        tmr_chipselect = 1'b1;
        tmr_address    = TMR_CONTROL;
      end
      ST_CLR: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = TMR_STATUS;
      end
      default: ;
    endcase
  end

  // A new load wins over the IDLE consumption in the same cycle, so a
  // request arriving mid-sequence still forces a full re-sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= DEFAULT_PERIOD;
      r_pend   <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_period <= cfg_period;
        r_pend   <= 1'b1;
      end else if (w_pend_take) begin
        r_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_error <= 1'b0;
    end else if (r_state == ST_CHK) begin
      r_error <= (tmr_readdata[3:0] != CTRL_RUN[3:0]);
    end
  end

  assign w_tick = (r_state == ST_CLR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_count <= '0;
    end else if (w_tick) begin
      r_tick_count <= r_tick_count + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_sched_channel #(
      .DIV_W (DIV_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .i_tick  (w_tick),
      .i_en    (ch_en[g]),
      .i_div   (ch_div[g*DIV_W +: DIV_W]),
      .o_event (ch_event[g])
    );
  end

  assign cfg_busy   = (r_state != ST_IDLE) || r_pend;
  assign cfg_error  = r_error;
  assign tick_count = r_tick_count;

endmodule
